// File: rtl/float_minmax_tracker.sv
// float_minmax_tracker: per-frame running max/min of sign-magnitude floats; FLOAT_MINMAX_SIGNED_ZERO_EQ_EN makes -0 equal +0
module float_minmax_tracker #(
  parameter int EXP_W = 4,
  parameter int FRAC_W = 8,
  parameter int MAX_LEN = 256,
  localparam int IDX_W = $clog2(MAX_LEN),
  localparam int KW = 1 + EXP_W + FRAC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_sign,
  input  logic [EXP_W-1:0]  s_exp,
  input  logic [FRAC_W-1:0] s_frac,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              max_sign,
  output logic [EXP_W-1:0]  max_exp,
  output logic [FRAC_W-1:0] max_frac,
  output logic              min_sign,
  output logic [EXP_W-1:0]  min_exp,
  output logic [FRAC_W-1:0] min_frac,
  output logic [IDX_W-1:0]  max_idx,
  output logic [IDX_W-1:0]  min_idx,
  output logic [IDX_W:0]    count
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state, state_nxt;
  logic accept, first, gt, lt, close;
  localparam logic [IDX_W:0] LAST = (IDX_W+1)'(MAX_LEN - 1);

  function automatic logic [KW-1:0] key(input logic s, input logic [EXP_W-1:0] e, input logic [FRAC_W-1:0] f);
    logic n;
`ifdef FLOAT_MINMAX_SIGNED_ZERO_EQ_EN
    n = s & (|{e, f});
`else
    n = s;
`endif
    return n ? {1'b0, ~e, ~f} : {1'b1, e, f};
  endfunction

  // state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nxt;

  // next state and handshake decode
  always_comb begin
    s_ready = state != DONE;
    m_valid = state == DONE;
    accept = s_valid & s_ready;
    first = state == IDLE;
    close = s_last | (state == ACCUM && count == LAST);
    state_nxt = state == DONE ? (m_ready ? IDLE : DONE) : accept ? (close ? DONE : ACCUM) : state;
    gt = key(s_sign, s_exp, s_frac) > key(max_sign, max_exp, max_frac);
    lt = key(s_sign, s_exp, s_frac) < key(min_sign, min_exp, min_frac);
  end

  // running extremes, their indices and the sample count
  always_ff @(posedge clk) begin
    if (reset) begin
      {max_sign, max_exp, max_frac, min_sign, min_exp, min_frac} <= '0;
      max_idx <= '0;
      min_idx <= '0;
      count <= '0;
    end else if (accept) begin
      if (first || gt) begin
        {max_sign, max_exp, max_frac} <= {s_sign, s_exp, s_frac};
        max_idx <= first ? '0 : count[IDX_W-1:0];
      end
      if (first || lt) begin
        {min_sign, min_exp, min_frac} <= {s_sign, s_exp, s_frac};
        min_idx <= first ? '0 : count[IDX_W-1:0];
      end
      count <= first ? (IDX_W+1)'(1) : count + 1'b1;
    end
  end
endmodule

// File: tb/tb_float_minmax_tracker.sv
// tb_float_minmax_tracker: directed vectors for float_minmax_tracker with MAX_LEN=4
module tb_float_minmax_tracker;
  logic clk = 0, reset = 1;
  logic s_valid = 0, s_ready, s_sign = 0, s_last = 0, m_valid, m_ready = 0;
  logic [3:0] s_exp = 0, max_exp, min_exp;
  logic [7:0] s_frac = 0, max_frac, min_frac;
  logic max_sign, min_sign;
  logic [1:0] max_idx, min_idx;
  logic [2:0] count;
  int passed = 0, total = 0;

  float_minmax_tracker #(.EXP_W(4), .FRAC_W(8), .MAX_LEN(4)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_sign(s_sign),
    .s_exp(s_exp), .s_frac(s_frac), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
    .max_sign(max_sign), .max_exp(max_exp), .max_frac(max_frac),
    .min_sign(min_sign), .min_exp(min_exp), .min_frac(min_frac),
    .max_idx(max_idx), .min_idx(min_idx), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send(input logic sg, input logic [3:0] e, input logic [7:0] f, input logic l);
    s_valid = 1; s_sign = sg; s_exp = e; s_frac = f; s_last = l;
    @(posedge clk); #1;
    s_valid = 0; s_last = 0;
  endtask

  task automatic consume();
    m_ready = 1;
    check("s_ready_in_done", s_ready, 0);
    @(posedge clk); #1;
    m_ready = 0;
    check("m_valid_after_consume", m_valid, 0);
    check("s_ready_after_consume", s_ready, 1);
  endtask

  task automatic result(input string tag, input logic [12:0] mx, input logic [12:0] mn, input int mxi, input int mni, input int c);
    check({tag, "_m_valid"}, m_valid, 1);
    check({tag, "_max"}, {max_sign, max_exp, max_frac}, mx);
    check({tag, "_min"}, {min_sign, min_exp, min_frac}, mn);
    check({tag, "_max_idx"}, max_idx, mxi);
    check({tag, "_min_idx"}, min_idx, mni);
    check({tag, "_count"}, count, c);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_count", count, 0);
    check("rst_fields", {max_sign, max_exp, max_frac, min_sign, min_exp, min_frac, max_idx, min_idx}, 0);

    send(0, 3, 8'h10, 0);
    send(1, 5, 8'h80, 0);
    send(0, 6, 8'h01, 0);
    check("f1_accum_m_valid", m_valid, 0);
    check("f1_accum_s_ready", s_ready, 1);
    send(0, 6, 8'h00, 1);
    result("f1", {1'b0, 4'd6, 8'h01}, {1'b1, 4'd5, 8'h80}, 2, 1, 4);
    consume();

    send(1, 2, 8'h40, 1);
    result("single", {1'b1, 4'd2, 8'h40}, {1'b1, 4'd2, 8'h40}, 0, 0, 1);
    consume();

    send(0, 1, 8'h05, 0);
    send(0, 1, 8'h05, 0);
    send(0, 1, 8'h05, 1);
    result("ties", {1'b0, 4'd1, 8'h05}, {1'b0, 4'd1, 8'h05}, 0, 0, 3);
    consume();

    send(0, 1, 8'h00, 0);
    send(0, 7, 8'hff, 0);
    send(1, 7, 8'hff, 0);
    check("len_before_close", m_valid, 0);
    send(0, 2, 8'h03, 0);
    result("len", {1'b0, 4'd7, 8'hff}, {1'b1, 4'd7, 8'hff}, 1, 2, 4);
    s_valid = 1; s_sign = 1; s_exp = 4'hf; s_frac = 8'hff;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_s_ready", s_ready, 0);
      result("hold", {1'b0, 4'd7, 8'hff}, {1'b1, 4'd7, 8'hff}, 1, 2, 4);
    end
    s_valid = 0;
    consume();

    send(1, 0, 8'h00, 0);
    send(0, 0, 8'h00, 1);
`ifdef FLOAT_MINMAX_SIGNED_ZERO_EQ_EN
    result("zero", {1'b1, 4'd0, 8'h00}, {1'b1, 4'd0, 8'h00}, 0, 0, 2);
`else
    result("zero", {1'b0, 4'd0, 8'h00}, {1'b1, 4'd0, 8'h00}, 1, 0, 2);
`endif
    consume();

    send(0, 4, 8'h11, 0);
    send(0, 5, 8'h22, 0);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    check("midrst_m_valid", m_valid, 0);
    check("midrst_s_ready", s_ready, 1);
    check("midrst_count", count, 0);
    send(0, 3, 8'h33, 1);
    result("post_rst", {1'b0, 4'd3, 8'h33}, {1'b0, 4'd3, 8'h33}, 0, 0, 1);
    consume();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
